// File: rtl/control_sequencer.sv
// Microcoded control unit for the 8-bit bus computer: fetch/execute micro-step sequencer and strobe decode.
// Latency: strobes are a combinational decode of the current micro-step; one micro-step per clock, 3..5 clocks per instruction.
// Backpressure: none; HLT freezes the sequencer until reset. Optional COND_JUMP_EN enables JC/JZ (otherwise opcodes 7/8 act as NOP).
//
// Ports:
//   clk, rst (async, active-high)         clock and reset
//   instr[7:0], carry, zero               IR contents (opcode in [7:4]) and latched ALU flags
//   pc_out/pc_inc/pc_load, mar_in,        bus drive and load strobes for every peripheral
//   ram_out/ram_in, ir_in/ir_out, a_in/a_out, b_in, alu_out/sub/flags_in, out_in
//   halt                                  clock-stop request, high while halted
//   step[2:0]                             current micro-step T0..T4 (debug)
module control_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] instr,
    input  logic       carry,
    input  logic       zero,
    output logic       pc_out,
    output logic       pc_inc,
    output logic       pc_load,
    output logic       mar_in,
    output logic       ram_out,
    output logic       ram_in,
    output logic       ir_in,
    output logic       ir_out,
    output logic       a_in,
    output logic       a_out,
    output logic       b_in,
    output logic       alu_out,
    output logic       sub,
    output logic       flags_in,
    output logic       out_in,
    output logic       halt,
    output logic [2:0] step
);

    typedef enum logic [2:0] {
        T0 = 3'd0,
        T1 = 3'd1,
        T2 = 3'd2,
        T3 = 3'd3,
        T4 = 3'd4
    } step_t;

    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    step_t      step_q, step_d;
    logic       halted_q, halted_d;
    logic [3:0] opcode;
    logic       jc_take;
    logic       jz_take;

    assign opcode = instr[7:4];

    // The operand nibble reaches the bus through the IR itself, never through this block.
    logic unused_operand;
    assign unused_operand = ^instr[3:0];

`ifdef COND_JUMP_EN
    assign jc_take = carry;
    assign jz_take = zero;
`else
    assign jc_take = 1'b0;
    assign jz_take = 1'b0;
    logic unused_flags;
    assign unused_flags = carry ^ zero;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            step_q   <= T0;
            halted_q <= 1'b0;
        end else begin
            step_q   <= step_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        step_d   = step_q;
        halted_d = halted_q;
        pc_out   = 1'b0;
        pc_inc   = 1'b0;
        pc_load  = 1'b0;
        mar_in   = 1'b0;
        ram_out  = 1'b0;
        ram_in   = 1'b0;
        ir_in    = 1'b0;
        ir_out   = 1'b0;
        a_in     = 1'b0;
        a_out    = 1'b0;
        b_in     = 1'b0;
        alu_out  = 1'b0;
        sub      = 1'b0;
        flags_in = 1'b0;
        out_in   = 1'b0;
        halt     = 1'b0;

        // Reset gates every strobe immediately, independent of the clock.
        if (rst) begin
            step_d   = T0;
            halted_d = 1'b0;
        end else if (halted_q) begin
            halt = 1'b1;
        end else begin
            case (step_q)
                T0: begin
                    pc_out = 1'b1;
                    mar_in = 1'b1;
                    step_d = T1;
                end
                T1: begin
                    ram_out = 1'b1;
                    ir_in   = 1'b1;
                    pc_inc  = 1'b1;
                    step_d  = T2;
                end
                T2: begin
                    step_d = T0;
                    case (opcode)
                        OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                            ir_out = 1'b1;
                            mar_in = 1'b1;
                            step_d = T3;
                        end
                        OP_LDI: begin
                            ir_out = 1'b1;
                            a_in   = 1'b1;
                        end
                        OP_JMP: begin
                            ir_out  = 1'b1;
                            pc_load = 1'b1;
                        end
                        OP_JC: begin
                            ir_out  = jc_take;
                            pc_load = jc_take;
                        end
                        OP_JZ: begin
                            ir_out  = jz_take;
                            pc_load = jz_take;
                        end
                        OP_OUT: begin
                            a_out  = 1'b1;
                            out_in = 1'b1;
                        end
                        OP_HLT: begin
                            // Step stays at T2 so the debug port shows where execution stopped.
                            halt     = 1'b1;
                            halted_d = 1'b1;
                            step_d   = T2;
                        end
                        default: ;
                    endcase
                end
                T3: begin
                    step_d = T0;
                    case (opcode)
                        OP_LDA: begin
                            ram_out = 1'b1;
                            a_in    = 1'b1;
                        end
                        OP_ADD, OP_SUB: begin
                            ram_out = 1'b1;
                            b_in    = 1'b1;
                            step_d  = T4;
                        end
                        OP_STA: begin
                            a_out  = 1'b1;
                            ram_in = 1'b1;
                        end
                        default: ;
                    endcase
                end
                T4: begin
                    step_d = T0;
                    if (opcode == OP_ADD || opcode == OP_SUB) begin
                        alu_out  = 1'b1;
                        a_in     = 1'b1;
                        flags_in = 1'b1;
                        sub      = (opcode == OP_SUB);
                    end
                end
                default: step_d = T0;
            endcase
        end
    end

    assign step = step_q;

endmodule

// File: tb/tb_control_sequencer.sv
module tb_control_sequencer;

    typedef struct packed {
        logic pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out;
        logic a_in, a_out, b_in, alu_out, sub, flags_in, out_in, halt;
    } strobes_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] instr = 8'h00;
    logic       carry = 1'b0;
    logic       zero = 1'b0;
    logic pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out;
    logic a_in, a_out, b_in, alu_out, sub, flags_in, out_in, halt;
    logic [2:0] step;

    int tests = 0;
    int fails = 0;

`ifdef COND_JUMP_EN
    localparam bit CJ = 1'b1;
`else
    localparam bit CJ = 1'b0;
`endif

    control_sequencer dut (
        .clk(clk), .rst(rst), .instr(instr), .carry(carry), .zero(zero),
        .pc_out(pc_out), .pc_inc(pc_inc), .pc_load(pc_load), .mar_in(mar_in),
        .ram_out(ram_out), .ram_in(ram_in), .ir_in(ir_in), .ir_out(ir_out),
        .a_in(a_in), .a_out(a_out), .b_in(b_in), .alu_out(alu_out), .sub(sub),
        .flags_in(flags_in), .out_in(out_in), .halt(halt), .step(step)
    );

    always #5 clk = ~clk;

    strobes_t obs;
    assign obs = {pc_out, pc_inc, pc_load, mar_in, ram_out, ram_in, ir_in, ir_out,
                  a_in, a_out, b_in, alu_out, sub, flags_in, out_in, halt};

    // Instruction length in clocks, straight from the instruction table.
    function automatic int exp_len(input logic [3:0] op);
        case (op)
            4'h1, 4'h4: return 4;
            4'h2, 4'h3: return 5;
            default:    return 3;
        endcase
    endfunction

    // Expected strobes for micro-step t of opcode op under the given flags.
    function automatic strobes_t exp_s(input logic [3:0] op, input int t, input logic c, input logic z);
        strobes_t s;
        s = '0;
        if (t == 0) begin
            s.pc_out = 1; s.mar_in = 1;
        end else if (t == 1) begin
            s.ram_out = 1; s.ir_in = 1; s.pc_inc = 1;
        end else if (t == 2) begin
            case (op)
                4'h1, 4'h2, 4'h3, 4'h4: begin s.ir_out = 1; s.mar_in = 1; end
                4'h5: begin s.ir_out = 1; s.a_in = 1; end
                4'h6: begin s.ir_out = 1; s.pc_load = 1; end
                4'h7: if (CJ && c) begin s.ir_out = 1; s.pc_load = 1; end
                4'h8: if (CJ && z) begin s.ir_out = 1; s.pc_load = 1; end
                4'hE: begin s.a_out = 1; s.out_in = 1; end
                4'hF: s.halt = 1;
                default: ;
            endcase
        end else if (t == 3) begin
            case (op)
                4'h1: begin s.ram_out = 1; s.a_in = 1; end
                4'h2, 4'h3: begin s.ram_out = 1; s.b_in = 1; end
                4'h4: begin s.a_out = 1; s.ram_in = 1; end
                default: ;
            endcase
        end else if (t == 4) begin
            s.alu_out = 1; s.a_in = 1; s.flags_in = 1; s.sub = (op == 4'h3);
        end
        return s;
    endfunction

    task automatic chk(input string tag, input logic [15:0] o, input logic [15:0] e);
        tests++;
        assert (o === e) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic bus_rules(input string tag);
        int n;
        n = int'(pc_out) + int'(ram_out) + int'(ir_out) + int'(a_out) + int'(alu_out);
        chk({tag, "_one_out"}, 16'(n <= 1), 16'd1);
        chk({tag, "_inc_load"}, 16'(pc_inc & pc_load), 16'd0);
    endtask

    // Entered just after a rising edge with the sequencer at T0; runs nsteps
    // micro-steps. During T0/T1 instr carries garbage, since it must be ignored then.
    task automatic do_steps(input string tag, input logic [7:0] ins, input logic c,
                            input logic z, input int nsteps);
        for (int t = 0; t < nsteps; t++) begin
            instr = (t < 2) ? 8'($urandom) : ins;
            carry = c;
            zero  = z;
            @(negedge clk);
            chk($sformatf("%s_op%h_t%0d_step", tag, ins[7:4], t), 16'(step), 16'(t));
            chk($sformatf("%s_op%h_t%0d_strb", tag, ins[7:4], t), obs, exp_s(ins[7:4], t, c, z));
            bus_rules(tag);
            @(posedge clk);
            #1;
        end
    endtask

    task automatic do_instr(input string tag, input logic [7:0] ins, input logic c, input logic z);
        do_steps(tag, ins, c, z, exp_len(ins[7:4]));
    endtask

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        chk("reset_step", 16'(step), 16'd0);
        chk("reset_strb", obs, 16'd0);
        @(posedge clk);
        #1 rst = 1'b0;

        // Directed patterns.
        do_instr("nop", 8'h00, 1'b0, 1'b0);
        do_instr("add", 8'h2E, 1'b0, 1'b0);
        do_instr("sub", 8'h37, 1'b1, 1'b1);
        do_instr("jc1", 8'h73, 1'b1, 1'b0);
        do_instr("jc0", 8'h73, 1'b0, 1'b1);
        do_instr("jz1", 8'h85, 1'b0, 1'b1);
        do_instr("jz0", 8'h85, 1'b1, 1'b0);
        for (int op = 0; op < 15; op++)
            do_instr("sweep", {4'(op), 4'(op)}, 1'b1, 1'b1);

        // Randomized instruction stream (HLT excluded so the stream keeps going).
        for (int i = 0; i < 80; i++) begin
            logic [7:0] ins;
            ins = 8'($urandom);
            if (ins[7:4] == 4'hF) ins[7:4] = 4'($urandom_range(0, 14));
            do_instr("rand", ins, 1'($urandom), 1'($urandom));
        end

        // Reset in the middle of T3 of STA 5.
        do_steps("sta", 8'h45, 1'b0, 1'b0, 3);
        #2;
        chk("sta_t3_step", 16'(step), 16'd3);
        chk("sta_t3_strb", obs, exp_s(4'h4, 3, 1'b0, 1'b0));
        rst = 1'b1;
        #1;
        chk("midrst_strb", obs, 16'd0);
        chk("midrst_step", 16'(step), 16'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        do_instr("after_midrst", 8'h00, 1'b0, 1'b0);

        // Halt: frozen at T2 with only halt asserted, until reset.
        do_instr("hlt", 8'hF0, 1'b0, 1'b0);
        for (int i = 0; i < 20; i++) begin
            instr = 8'($urandom);
            carry = 1'($urandom);
            zero  = 1'($urandom);
            @(negedge clk);
            chk($sformatf("halted_step_%0d", i), 16'(step), 16'd2);
            chk($sformatf("halted_strb_%0d", i), obs, 16'h0001);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        #1;
        chk("hltrst_step", 16'(step), 16'd0);
        chk("hltrst_strb", obs, 16'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        do_instr("after_hlt", 8'h2E, 1'b0, 1'b0);
        do_instr("after_hlt", 8'hE0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
